// File: rtl/sprite_pkg.sv
// Shared sprite constants: FSM state encoding and bitmap geometry.
package sprite_pkg;

  localparam logic [2:0] ST_WAIT_VSTART = 3'd0;
  localparam logic [2:0] ST_WAIT_LOAD   = 3'd1;
  localparam logic [2:0] ST_LOAD_SETUP  = 3'd2;
  localparam logic [2:0] ST_LOAD_FETCH  = 3'd3;
  localparam logic [2:0] ST_WAIT_HSTART = 3'd4;
  localparam logic [2:0] ST_DRAW        = 3'd5;
  localparam logic [2:0] ST_NEXT_ROW    = 3'd6;

  localparam int SPRITE_ROWS           = 16;
  localparam int SPRITE_ROW_BITS       = 8;
  localparam int SPRITE_WIDTH_MIRRORED = 16;

  typedef logic [$clog2(SPRITE_ROWS)-1:0] row_addr_t;
  typedef logic [SPRITE_ROW_BITS-1:0]     row_bits_t;

endpackage

// File: rtl/sprite_renderer.sv
// Per-line sprite renderer: fetches one ROM row per horizontal blank and
// shifts it out as a 1-bit pixel stream, optionally mirrored to 16 pixels.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int HEIGHT = 16,
  parameter int MIRROR = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vstart,
  input  logic       load,
  input  logic       hstart,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_bits,
  output logic       gfx,
  output logic       in_progress
);

  localparam row_addr_t LAST  = (MIRROR != 0) ? row_addr_t'(SPRITE_WIDTH_MIRRORED - 1)
                                              : row_addr_t'(SPRITE_ROW_BITS - 1);
  localparam row_addr_t YLAST = row_addr_t'(HEIGHT - 1);

  // Pixels 0..7 take bits 0..7; pixels 8..15 walk back down bits 7..0.
  function automatic logic [2:0] mirror_sel(input row_addr_t x);
    return x[3] ? ~x[2:0] : x[2:0];
  endfunction

  logic [2:0] state_q, state_d;
  row_addr_t  ycount_q, ycount_d;
  row_addr_t  xcount_q, xcount_d;
  row_bits_t  rowbits_q, rowbits_d;
  row_addr_t  rom_addr_q, rom_addr_d;

  // Next-state logic: strobes only matter in their own wait state.
  always_comb begin
    state_d    = state_q;
    ycount_d   = ycount_q;
    xcount_d   = xcount_q;
    rowbits_d  = rowbits_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      ST_WAIT_VSTART: begin
        ycount_d = '0;
        if (vstart) state_d = ST_WAIT_LOAD;
      end
      ST_WAIT_LOAD: begin
        if (load) state_d = ST_LOAD_SETUP;
      end
      ST_LOAD_SETUP: begin
        rom_addr_d = ycount_q;
        state_d    = ST_LOAD_FETCH;
      end
      ST_LOAD_FETCH: begin
        rowbits_d = rom_bits;
        state_d   = ST_WAIT_HSTART;
      end
      ST_WAIT_HSTART: begin
        if (hstart) begin
          xcount_d = '0;
          state_d  = ST_DRAW;
        end
      end
      ST_DRAW: begin
        xcount_d = xcount_q + 1'b1;
        if (xcount_q == LAST) state_d = ST_NEXT_ROW;
      end
      ST_NEXT_ROW: begin
        if (ycount_q == YLAST) begin
          state_d = ST_WAIT_VSTART;
        end else begin
          ycount_d = ycount_q + 1'b1;
          state_d  = ST_WAIT_LOAD;
        end
      end
      default: state_d = ST_WAIT_VSTART;
    endcase
  end

  // State registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT_VSTART;
      ycount_q   <= '0;
      xcount_q   <= '0;
      rowbits_q  <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ycount_q   <= ycount_d;
      xcount_q   <= xcount_d;
      rowbits_q  <= rowbits_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // gfx is decoded from registered state so reset blanks it in the same cycle.
  assign gfx         = (state_q == ST_DRAW) & rowbits_q[mirror_sel(xcount_q)];
  assign in_progress = (state_q != ST_WAIT_VSTART);
  assign rom_addr    = rom_addr_q;

endmodule
